// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures rising-edge interval of a pulse stream as a divider top value
// Optional PERIOD_METER_MATCH_EN: publish only when two consecutive raw measurements agree.
module period_meter #(
  parameter int bits = 8
) (
  input  logic            n_reset,
  input  logic            clk,
  input  logic            clear,
  input  logic            in,
  output logic [bits-1:0] top,
  output logic            valid,
  output logic            locked,
  output logic            overflow
);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  localparam logic [bits-1:0] CNT_MAX = {bits{1'b1}};
  localparam logic [bits-1:0] CNT_ONE = bits'(1);

  state_t          state_q;
  logic            s1_q, s2_q, d_q;
  logic [bits-1:0] cnt_q, cnt_d;
  logic [bits-1:0] top_q;
  logic            valid_q, locked_q, overflow_q;
  logic            rise;
`ifdef PERIOD_METER_MATCH_EN
  logic [bits-1:0] prev_q;
  logic            prev_ok_q;
`endif

  assign rise  = s2_q & ~d_q;
  assign cnt_d = cnt_q + CNT_ONE;

  assign top      = top_q;
  assign valid    = valid_q;
  assign locked   = locked_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      d_q        <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      top_q      <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      overflow_q <= 1'b0;
`ifdef PERIOD_METER_MATCH_EN
      prev_q     <= '0;
      prev_ok_q  <= 1'b0;
`endif
    end else begin
      s1_q    <= in;
      s2_q    <= s1_q;
      d_q     <= s2_q;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // clear beats a coincident edge, so the edge cannot start a measurement
          if (clear) begin
            locked_q   <= 1'b0;
            overflow_q <= 1'b0;
`ifdef PERIOD_METER_MATCH_EN
            prev_ok_q  <= 1'b0;
`endif
          end else if (rise) begin
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (clear) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            locked_q   <= 1'b0;
            overflow_q <= 1'b0;
`ifdef PERIOD_METER_MATCH_EN
            prev_ok_q  <= 1'b0;
`endif
          end else if (rise) begin
            cnt_q      <= '0;
            overflow_q <= 1'b0;
`ifdef PERIOD_METER_MATCH_EN
            prev_q    <= cnt_q;
            prev_ok_q <= 1'b1;
            if (prev_ok_q && (prev_q == cnt_q)) begin
              top_q    <= cnt_q;
              valid_q  <= 1'b1;
              locked_q <= 1'b1;
            end else begin
              locked_q <= 1'b0;
            end
`else
            top_q    <= cnt_q;
            valid_q  <= 1'b1;
            locked_q <= 1'b1;
`endif
          end else if (cnt_q == CNT_MAX) begin
            // timeout is checked before the increment, so cnt never wraps
            state_q    <= IDLE;
            cnt_q      <= '0;
            overflow_q <= 1'b1;
            locked_q   <= 1'b0;
`ifdef PERIOD_METER_MATCH_EN
            prev_ok_q  <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - self-checking bench for period_meter
module tb_period_meter;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       clear = 1'b0;
  logic       stim_in = 1'b0;
  logic       use_div = 1'b0;
  logic       dut_in;
  logic [7:0] top;
  logic       valid, locked, overflow;

  logic [1:0] div_cnt = 2'd0;
  logic       div_out;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] top;
    int         due;
  } exp_t;
  exp_t sb[$];

  period_meter #(.bits(8)) dut (
    .n_reset (n_reset),
    .clk     (clk),
    .clear   (clear),
    .in      (dut_in),
    .top     (top),
    .valid   (valid),
    .locked  (locked),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) div_cnt <= div_cnt + 2'd1;
  assign div_out = (div_cnt == 2'd3);
  assign dut_in  = use_div ? div_out : stim_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int exp_top);
    exp_t e;
    e.top = exp_top[7:0];
    e.due = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic edge_gap(input int gap, input bit pub, input int exp_top);
    @(negedge clk);
    stim_in = 1'b1;
    if (pub) push_exp(exp_top);
    @(negedge clk);
    stim_in = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1) begin
      check("valid_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("valid_top", 32'(top), 32'(e.top));
        check("valid_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      check("valid_on_due", 32'(valid), 32'd1);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_top", 32'(top), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    n_reset = 1'b1;

    edge_gap(6, 1'b0, 0);
    edge_gap(6, 1'b1, 5);
    edge_gap(6, 1'b1, 5);
    edge_gap(6, 1'b1, 5);
    check("p6_locked", 32'(locked), 32'd1);
    check("p6_top", 32'(top), 32'd5);
    check("p6_overflow", 32'(overflow), 32'd0);

    edge_gap(10, 1'b1, 5);
    edge_gap(10, 1'b1, 9);
    check("p10_top", 32'(top), 32'd9);
    edge_gap(256, 1'b1, 9);
    edge_gap(257, 1'b1, 255);
    check("p256_top", 32'(top), 32'd255);
    check("p256_overflow", 32'(overflow), 32'd0);
    check("p256_locked", 32'(locked), 32'd1);
    edge_gap(10, 1'b0, 0);
    check("p257_overflow", 32'(overflow), 32'd1);
    check("p257_locked", 32'(locked), 32'd0);
    edge_gap(12, 1'b1, 9);
    check("after_ovf_top", 32'(top), 32'd9);
    check("after_ovf_overflow", 32'(overflow), 32'd0);
    check("after_ovf_locked", 32'(locked), 32'd1);

    edge_gap(12, 1'b1, 11);
    @(negedge clk);
    stim_in = 1'b1;
    push_exp(11);
    @(negedge clk);
    stim_in = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_locked", 32'(locked), 32'd0);
    check("clr_top", 32'(top), 32'd11);
    repeat (6) @(negedge clk);
    edge_gap(12, 1'b0, 0);
    edge_gap(12, 1'b1, 11);
    check("clr_relock_top", 32'(top), 32'd11);
    check("clr_relock_locked", 32'(locked), 32'd1);

    edge_gap(6, 1'b1, 11);
    edge_gap(6, 1'b1, 5);
    @(negedge clk);
    stim_in = 1'b1;
    push_exp(5);
    @(negedge clk);
    stim_in = 1'b0;
    repeat (3) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("arst_top", 32'(top), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    edge_gap(6, 1'b0, 0);
    edge_gap(6, 1'b1, 5);
    check("arst_relock", 32'(locked), 32'd1);

    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("pre_div_locked", 32'(locked), 32'd0);
    if (div_out) @(negedge clk);
    use_div = 1'b1;
    begin
      int n_edges = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (div_out) begin
          if (n_edges > 0) push_exp(3);
          n_edges++;
        end
      end
    end
    check("div_locked", 32'(locked), 32'd1);
    check("div_top", 32'(top), 32'd3);
    @(negedge clk);
    use_div = 1'b0;
    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the interval between rising edges of a pulse stream in `clk` cycles.
- Reports the interval as a `top` value, defined as (interval in clk cycles) − 1. A divider configured with that `top` and clocked by `clk` reproduces the measured pulse rate.
- Sits on the consumer side of divider/timer pulse outputs: APU timer checking, frame-rate detection, and bench loopback of divider chains.

Parameters:
- bits, 8, width of the interval counter and of the `top` output; maximum measurable interval is 2^bits clk cycles.

Ports:
- n_reset  input  1  asynchronous, active-low reset
- clk  input  1  measurement clock
- clear  input  1  synchronous; abandons the current measurement and returns to IDLE
- in  input  1  pulse stream; asynchronous to clk, so it is synchronized internally
- top  output  bits  last published measurement (interval − 1)
- valid  output  1  one-clk strobe when `top` is updated
- locked  output  1  high while consecutive intervals are being measured without timeout
- overflow  output  1  sticky; set when an interval exceeds 2^bits cycles

Behaviour:
- Reset: n_reset is asynchronous and active-low. It clears all registers immediately:
  - sync flops s1, s2, d = 0
  - state = IDLE, cnt = 0
  - top = 0, valid = 0, locked = 0, overflow = 0
- Synchronizer: `in` passes through s1 → s2, and d is s2 delayed by one clk. edge = s2 & ~d.
  - The edge is asserted 2 clk after `in` is sampled high.
  - `in` already high at reset release produces an edge.
- valid defaults to 0 every cycle. It is high only on the single clk after a publishing edge.
- State IDLE:
  - cnt held at 0.
  - On edge: go to MEASURE with cnt = 0. Nothing is published.
- State MEASURE, in priority order:
  1. clear: go to IDLE, cnt = 0, locked = 0, overflow = 0; `top` is retained.
  2. edge: top ← cnt, valid ← 1, locked ← 1, overflow ← 0, cnt ← 0; stay in MEASURE.
  3. cnt == 2^bits − 1 with no edge: overflow ← 1, locked ← 0, go to IDLE; `top` is retained.
  4. Otherwise: cnt ← cnt + 1.
- clear in IDLE clears locked and overflow. clear together with an edge: clear wins and the edge is discarded; it does not start a measurement.
- Interval rule: edges N clk apart give top = N − 1.
  - N = 2^bits is still valid: an edge on the cnt == max cycle publishes max.
  - N > 2^bits raises overflow.
- Arithmetic: cnt is bits wide and never wraps; the timeout check precedes the increment.
- Minimum interval: 2 clk, since edge detection requires a low sample between edges. A steady-high `in` produces no further edges.
- Latency: valid and the new `top` appear 3 clk after the `in` rising edge that closes the interval.

Optional Feature:
- Macro: PERIOD_METER_MATCH_EN
- Defined: a raw measurement is published only if it equals the previous raw measurement (held in a bits-wide register prev, with a prev_ok flag).
  - First measurement after IDLE: never published; it is stored in prev and sets prev_ok.
  - Mismatch: no valid, `top` unchanged, locked ← 0; prev ← the new value.
  - Match: publish as normal (top, valid, locked ← 1).
  - prev_ok is cleared by reset, clear, and timeout.
- Not defined: every edge in MEASURE publishes; prev and prev_ok are not built.

Test Plan (bits = 8):
- Edges every 6 clk after reset → first valid on the second edge (+3 clk latency), top = 5, locked = 1; valid repeats every 6 clk. With MATCH_EN, the first valid is on the third edge.
- Edge spacing 256 clk → top = 255, valid, overflow = 0. Spacing 257 → overflow = 1 and locked = 0 on the cycle after cnt = 255, state IDLE; the next edge publishes nothing. A subsequent 10-clk interval → top = 9, overflow = 0.
- Pulse stream of period 12, clear asserted 4 clk into an interval → locked = 0 and top = 11 retained; the next edge only restarts measurement; the following edge gives valid with top = 11.
- n_reset pulled low mid-interval, asynchronously to clk → top, valid, locked and overflow are 0 before the next clk edge. The first edge after release produces no valid.
- Interval changes from 6 to 10 clk → top = 5, then 9 on the first 10-clk edge. With MATCH_EN: locked drops on the first 10-clk edge with no valid; top = 9 is published on the second 10-clk edge.
- Divider output with top = 3, clocked by clk, drives `in` → steady top = 3, valid every 4 clk, locked = 1.
